input_conditioner: RTL and testbench

Conditions one asynchronous, possibly bouncing input level before it reaches the team's D-flip-flop register stages. The block does three things in order:
- synchronises the input into the `clk` domain;
- debounces it with a counter/FSM;
- produces a clean level plus single-cycle rise and fall pulses, and counts rejected glitches.

It sits directly upstream of the flop stages and drives their `d_i`.

---
 rtl/cond_pkg.sv | 20 ++
 rtl/sync_chain.sv | 44 ++++
 rtl/input_conditioner.sv | 149 ++++++++++++++
 tb/tb_input_conditioner.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cond_pkg
// Description : Types and constants shared by the input conditioning blocks:
//               the debounce FSM state type and the glitch counter
//               width and saturation limit.
// Revision    : 1.0 - initial release
// ============================================================================
package cond_pkg;

  typedef enum logic [0:0] {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } cond_state_t;

  localparam int          GLITCH_W   = 8;
  localparam logic [7:0]  GLITCH_MAX = 8'hFF;

endpackage : cond_pkg
`default_nettype wire

// File: rtl/sync_chain.sv
`default_nettype none
// ============================================================================
// Module      : sync_chain
// Description : Shift-register synchroniser for one asynchronous level.
//               Every stage resets to RST_VAL.
//   clk   in  1  : destination clock
//   reset in  1  : asynchronous, active-high reset
//   d     in  1  : asynchronous input level
//   q     out 1  : synchronised level (last stage)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_chain #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_q;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge reset) begin
          if (reset) stage_q[gi] <= RST_VAL;
          else       stage_q[gi] <= d;
        end
      end else begin : g_next
        always_ff @(posedge clk or posedge reset) begin
          if (reset) stage_q[gi] <= RST_VAL;
          else       stage_q[gi] <= stage_q[gi-1];
        end
      end
    end
  endgenerate

  assign q = stage_q[STAGES-1];

endmodule : sync_chain
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner
// Description : Synchronises, debounces and edge-detects one asynchronous
//               input level. A new level is accepted only after it has been
//               seen for DEBOUNCE_CYCLES consecutive samples; shorter
//               excursions are counted as glitches (saturating).
//   clk          in  1 : clock
//   reset        in  1 : asynchronous, active-high reset
//   d_i          in  1 : raw asynchronous input
//   clr_i        in  1 : synchronous clear of glitch_cnt_o
//   q_o          out 1 : debounced, registered level
//   rise_o       out 1 : one-cycle pulse on q_o 0->1
//   fall_o       out 1 : one-cycle pulse on q_o 1->0
//   busy_o       out 1 : high while a level change is being qualified
//   glitch_cnt_o out 8 : rejected level changes, saturates at 255
// Revision    : 1.0 - initial release
// ============================================================================
module input_conditioner
  import cond_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                d_i,
  input  logic                clr_i,
  output logic                q_o,
  output logic                rise_o,
  output logic                fall_o,
  output logic                busy_o,
  output logic [GLITCH_W-1:0] glitch_cnt_o
);

  localparam int            CNT_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] ST_STABLE = STABLE;
  localparam logic [0:0] ST_CHECK  = CHECK;

  // The FSM's own registers form the final register stage, so the chain
  // ahead of it is one shorter than SYNC_STAGES: s changes after edge
  // SYNC_STAGES-1 counted from the edge that first captures d_i.
  localparam int SYNC_DEPTH = SYNC_STAGES - 1;

  logic s;

  logic [0:0]          state_q,  state_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic                q_q,      q_d;
  logic                rise_q,   rise_d;
  logic                fall_q,   fall_d;
  logic                busy_q,   busy_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic                glitch_inc;

  sync_chain #(
    .STAGES  (SYNC_DEPTH),
    .RST_VAL (RESET_LEVEL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (d_i),
    .q     (s)
  );

  // Debounce FSM. In CHECK a reversion takes priority over acceptance, so
  // a level that drops back on the very sample that would have completed
  // the window is still a glitch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    glitch_inc = 1'b0;

    case (state_q)
      ST_STABLE: begin
        if (s != q_q) begin
          state_d = ST_CHECK;
          cnt_d   = CNT_ONE;
        end
      end
      ST_CHECK: begin
        if (s == q_q) begin
          state_d    = ST_STABLE;
          cnt_d      = '0;
          glitch_inc = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          q_d     = s;
          rise_d  = s;
          fall_d  = ~s;
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == ST_CHECK);
  end

  // Clear beats a simultaneous increment; the counter holds at its maximum.
  always_comb begin
    glitch_d = glitch_q;
    if (clr_i) begin
      glitch_d = '0;
    end else if (glitch_inc && (glitch_q != GLITCH_MAX)) begin
      glitch_d = glitch_q + GLITCH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_STABLE;
      cnt_q    <= '0;
      q_q      <= RESET_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      busy_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      q_q      <= q_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      busy_q   <= busy_d;
      glitch_q <= glitch_d;
    end
  end

  assign q_o          = q_q;
  assign rise_o       = rise_q;
  assign fall_o       = fall_q;
  assign busy_o       = busy_q;
  assign glitch_cnt_o = glitch_q;

endmodule : input_conditioner
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_conditioner
// Description : Self-checking bench for input_conditioner. Instance A uses
//               DEBOUNCE_CYCLES=4, SYNC_STAGES=2, RESET_LEVEL=0; instance B
//               uses DEBOUNCE_CYCLES=2, SYNC_STAGES=3, RESET_LEVEL=1.
//               A run-length reference model tracks instance A.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b0, d_a = 1'b0, clr_a = 1'b0;
  logic       q_a, rise_a, fall_a, busy_a;
  logic [7:0] g_a;
  logic       rst_b = 1'b0, d_b = 1'b0, clr_b = 1'b0;
  logic       q_b, rise_b, fall_b, busy_b;
  logic [7:0] g_b;

  int checks = 0;
  int errors = 0;

  input_conditioner #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0)) u_a (
    .clk(clk), .reset(rst_a), .d_i(d_a), .clr_i(clr_a), .q_o(q_a),
    .rise_o(rise_a), .fall_o(fall_a), .busy_o(busy_a), .glitch_cnt_o(g_a));

  input_conditioner #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(2), .RESET_LEVEL(1'b1)) u_b (
    .clk(clk), .reset(rst_b), .d_i(d_b), .clr_i(clr_b), .q_o(q_b),
    .rise_o(rise_b), .fall_o(fall_b), .busy_o(busy_b), .glitch_cnt_o(g_b));

  // Reference model: a level seen on the synchronised input is accepted once
  // it has been different from q for WINDOW consecutive samples; a run that
  // ends early is one glitch. pipe holds recent d samples, newest in bit 0.
  typedef struct {
    logic [7:0] pipe;
    logic       q;
    logic       rise;
    logic       fall;
    logic       busy;
    int         run;
    int         glitch;
  } mdl_t;

  function automatic mdl_t mdl_reset(logic rl);
    mdl_t m;
    m.pipe = {8{rl}};
    m.q = rl; m.rise = 1'b0; m.fall = 1'b0; m.busy = 1'b0;
    m.run = 0; m.glitch = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, logic d, logic clr, int depth, int window);
    mdl_t n = m;
    logic s = m.pipe[depth-1];
    n.pipe = {m.pipe[6:0], d};
    n.rise = 1'b0;
    n.fall = 1'b0;
    if (s != m.q) begin
      if (m.run + 1 >= window) begin
        n.q = s; n.rise = s; n.fall = !s; n.run = 0; n.busy = 1'b0;
      end else begin
        n.run = m.run + 1; n.busy = 1'b1;
      end
    end else begin
      if (m.run > 0 && m.glitch < 255) n.glitch = m.glitch + 1;
      n.run = 0; n.busy = 1'b0;
    end
    if (clr) n.glitch = 0;
    return n;
  endfunction

  mdl_t ma;
  always @(posedge clk or posedge rst_a) begin
    if (rst_a) ma <= mdl_reset(1'b0);
    else       ma <= mdl_step(ma, d_a, clr_a, 1, 4);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Two-cycle high excursion on d_a followed by enough low cycles to settle.
  task automatic do_bounce(output bit saw_pulse);
    saw_pulse = 1'b0;
    d_a = 1'b1;
    for (int i = 0; i < 2; i++) begin tick(); if (rise_a || fall_a) saw_pulse = 1'b1; end
    d_a = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); if (rise_a || fall_a) saw_pulse = 1'b1; end
  endtask

  task automatic test_reset;
    #3;
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    checks++;
    if ({q_a, rise_a, fall_a, busy_a, g_a} !== {4'b0000, 8'd0}) begin
      errors++;
      $display("FAIL reset_async_a: got q/r/f/b=%b%b%b%b g=%0d want 0000 g=0", q_a, rise_a, fall_a, busy_a, g_a);
    end
    checks++;
    if ({q_b, rise_b, fall_b, busy_b, g_b} !== {4'b1000, 8'd0}) begin
      errors++;
      $display("FAIL reset_async_b: got q/r/f/b=%b%b%b%b g=%0d want 1000 g=0", q_b, rise_b, fall_b, busy_b, g_b);
    end
    tick(); tick();
    rst_a = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      checks++;
      if ({q_a, rise_a, fall_a, busy_a} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_release edge %0d: got q/r/f/b=%b%b%b%b want 0000", e, q_a, rise_a, fall_a, busy_a);
      end
    end
  endtask

  task automatic test_clean_edge(input logic lvl);
    logic [3:0] exp;
    d_a = lvl;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp[3] = (e >= 5) ? lvl : !lvl;
      exp[2] = (e == 5) && lvl;
      exp[1] = (e == 5) && !lvl;
      exp[0] = (e >= 2) && (e <= 4);
      checks++;
      if ({q_a, rise_a, fall_a, busy_a} !== exp) begin
        errors++;
        $display("FAIL clean_%s edge %0d: got q/r/f/b=%b%b%b%b want %b",
                 lvl ? "rise" : "fall", e, q_a, rise_a, fall_a, busy_a, exp);
      end
    end
    checks++;
    if (g_a !== 8'd0) begin
      errors++;
      $display("FAIL clean_glitch: got %0d want 0", g_a);
    end
  endtask

  task automatic test_bounce;
    bit p;
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    checks++;
    if (g_a !== 8'd0) begin errors++; $display("FAIL clear: got %0d want 0", g_a); end
    do_bounce(p);
    checks++;
    if (p || q_a !== 1'b0 || g_a !== 8'd1) begin
      errors++;
      $display("FAIL bounce: got pulse=%0d q=%b g=%0d want pulse=0 q=0 g=1", p, q_a, g_a);
    end
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (q_a !== 1'b0 || g_a !== 8'd1) begin
      errors++;
      $display("FAIL bounce_hold: got q=%b g=%0d want q=0 g=1", q_a, g_a);
    end
  endtask

  task automatic test_clear_collision;
    bit p;
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    for (int i = 0; i < 7; i++) do_bounce(p);
    checks++;
    if (g_a !== 8'd7) begin errors++; $display("FAIL collide_pre: got %0d want 7", g_a); end
    d_a = 1'b1; tick(); tick();
    d_a = 1'b0; tick();
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL collide_busy: got %b want 1", busy_a); end
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    checks++;
    if (g_a !== 8'd0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL collide: got g=%0d busy=%b want g=0 busy=0", g_a, busy_a);
    end
    tick(); tick();
    checks++;
    if (g_a !== 8'd0 || q_a !== 1'b0) begin
      errors++;
      $display("FAIL collide_after: got g=%0d q=%b want g=0 q=0", g_a, q_a);
    end
  endtask

  task automatic test_saturation;
    bit p;
    clr_a = 1'b1; tick(); clr_a = 1'b0;
    for (int i = 0; i < 254; i++) do_bounce(p);
    checks++;
    if (g_a !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d want 254", g_a); end
    for (int i = 0; i < 46; i++) do_bounce(p);
    checks++;
    if (g_a !== 8'd255 || q_a !== 1'b0) begin
      errors++;
      $display("FAIL sat_300: got g=%0d q=%b want g=255 q=0", g_a, q_a);
    end
  endtask

  task automatic test_reset_mid_check;
    int guard = 0;
    int rises = 0;
    d_a = 1'b1;
    while (busy_a !== 1'b1 && guard < 10) begin tick(); guard++; end
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL midreset_enter: got busy=%b want 1", busy_a); end
    tick(); tick();
    #2;
    rst_a = 1'b1;
    #1;
    checks++;
    if ({q_a, rise_a, fall_a, busy_a, g_a} !== {4'b0000, 8'd0}) begin
      errors++;
      $display("FAIL midreset_async: got q/r/f/b=%b%b%b%b g=%0d want 0000 g=0", q_a, rise_a, fall_a, busy_a, g_a);
    end
    tick();
    checks++;
    if ({q_a, rise_a, fall_a, busy_a} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_hold: got q/r/f/b=%b%b%b%b want 0000", q_a, rise_a, fall_a, busy_a);
    end
    rst_a = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (rise_a) rises++;
      checks++;
      if (rise_a !== (e == 5) || q_a !== (e >= 5) || fall_a !== 1'b0) begin
        errors++;
        $display("FAIL midreset_release edge %0d: got q=%b rise=%b fall=%b want q=%b rise=%b fall=0",
                 e, q_a, rise_a, fall_a, (e >= 5), (e == 5));
      end
    end
    checks++;
    if (rises != 1) begin errors++; $display("FAIL midreset_rises: got %0d want 1", rises); end
  endtask

  task automatic test_random;
    int hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        d_a  = ~d_a;
        hold = int'($urandom_range(1, 8));
      end
      hold--;
      clr_a = ($urandom_range(0, 31) == 0);
      tick();
      checks++;
      if ({q_a, rise_a, fall_a, busy_a} !== {ma.q, ma.rise, ma.fall, ma.busy} ||
          g_a !== 8'(ma.glitch)) begin
        errors++;
        $display("FAIL random cyc %0d: got q/r/f/b=%b%b%b%b g=%0d want %b%b%b%b g=%0d",
                 c, q_a, rise_a, fall_a, busy_a, g_a, ma.q, ma.rise, ma.fall, ma.busy, ma.glitch);
      end
    end
    clr_a = 1'b0;
  endtask

  task automatic test_sweep;
    checks++;
    if (q_b !== 1'b1 || rise_b !== 1'b0 || fall_b !== 1'b0) begin
      errors++;
      $display("FAIL sweep_reset: got q=%b r=%b f=%b want q=1 r=0 f=0", q_b, rise_b, fall_b);
    end
    d_b = 1'b0;
    rst_b = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (fall_b !== (e == 4) || q_b !== (e < 4) || rise_b !== 1'b0) begin
        errors++;
        $display("FAIL sweep edge %0d: got q=%b f=%b r=%b want q=%b f=%b r=0",
                 e, q_b, fall_b, rise_b, (e < 4), (e == 4));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean_edge(1'b1);
    test_clean_edge(1'b0);
    test_bounce();
    test_clear_collision();
    test_saturation();
    test_reset_mid_check();
    test_random();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_input_conditioner
`default_nettype wire
